// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift right/left and parallel load over WIDTH
// stages, with a shift counter that pulses frameDone on each completed WIDTH-shift frame.
module univ_shift_reg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic [1:0]                 mode,
    input  logic                       serialInMsb,
    input  logic                       serialInLsb,
    input  logic [WIDTH-1:0]           parIn,
    output logic [WIDTH-1:0]           parOut,
    output logic                       serialOutLsb,
    output logic                       serialOutMsb,
    output logic [$clog2(WIDTH)-1:0]   shiftCount,
    output logic                       frameDone
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        MODE_HOLD  = 2'b00,
        MODE_RIGHT = 2'b01,
        MODE_LEFT  = 2'b10,
        MODE_LOAD  = 2'b11
    } mode_e;

    logic [WIDTH-1:0] q, q_next;
    logic [CW-1:0]    count, count_next;
    logic             frame, frame_next;
    logic             shift;

    always_comb begin
        q_next     = q;
        count_next = count;
        frame_next = 1'b0;
        shift      = 1'b0;
        if (enable) begin
            case (mode_e'(mode))
                MODE_RIGHT: begin
                    q_next = {serialInMsb, q[WIDTH-1:1]};
                    shift  = 1'b1;
                end
                MODE_LEFT: begin
                    q_next = {q[WIDTH-2:0], serialInLsb};
                    shift  = 1'b1;
                end
                MODE_LOAD: begin
                    q_next     = parIn;
                    count_next = '0;
                end
                default: ;
            endcase
        end
        // Both shift directions advance the same frame counter.
        if (shift) begin
            if (count == LAST) begin
                count_next = '0;
                frame_next = 1'b1;
            end else begin
                count_next = count + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q     <= '0;
            count <= '0;
            frame <= 1'b0;
        end else begin
            q     <= q_next;
            count <= count_next;
            frame <= frame_next;
        end
    end

    assign parOut       = q;
    assign serialOutLsb = q[0];
    assign serialOutMsb = q[WIDTH-1];
    assign shiftCount   = count;
    assign frameDone    = frame;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed-vector bench for univ_shift_reg at WIDTH 8 with hand-computed expectations.
module tb_univ_shift_reg;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic [1:0] mode = 2'b00;
    logic       serialInMsb = 1'b0;
    logic       serialInLsb = 1'b0;
    logic [7:0] parIn = 8'h00;
    logic [7:0] parOut;
    logic       serialOutLsb;
    logic       serialOutMsb;
    logic [2:0] shiftCount;
    logic       frameDone;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned pulses;
    logic [7:0]  pattern;

    univ_shift_reg #(.WIDTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .mode         (mode),
        .serialInMsb  (serialInMsb),
        .serialInLsb  (serialInLsb),
        .parIn        (parIn),
        .parOut       (parOut),
        .serialOutLsb (serialOutLsb),
        .serialOutMsb (serialOutMsb),
        .shiftCount   (shiftCount),
        .frameDone    (frameDone)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Apply one set of inputs across a single rising edge, then settle for sampling.
    task automatic cycle(input logic en, input logic [1:0] md, input logic si_msb,
                         input logic si_lsb, input logic [7:0] p);
        enable      = en;
        mode        = md;
        serialInMsb = si_msb;
        serialInLsb = si_lsb;
        parIn       = p;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset dominates enable and a load.
        rst = 1'b1;
        cycle(1'b1, 2'b11, 1'b1, 1'b1, 8'($urandom));
        cycle(1'b1, 2'b11, 1'b1, 1'b1, 8'($urandom));
        check("rst_par", parOut, 8'h00);
        check("rst_cnt", shiftCount, 3'd0);
        check("rst_frm", frameDone, 1'b0);
        check("rst_lsb", serialOutLsb, 1'b0);
        check("rst_msb", serialOutMsb, 1'b0);
        rst = 1'b0;
        cycle(1'b0, 2'b11, 1'b1, 1'b1, 8'hFF);
        cycle(1'b1, 2'b00, 1'b1, 1'b1, 8'hFF);
        check("post_rst_par", parOut, 8'h00);
        check("post_rst_cnt", shiftCount, 3'd0);

        // Delay line: a single 1 emerges at serialOutLsb after exactly 8 shifts.
        for (int k = 1; k <= 8; k++) begin
            cycle(1'b1, 2'b01, (k == 1), 1'b0, 8'h00);
            check($sformatf("dly_lsb_%0d", k), serialOutLsb, (k == 8));
            check($sformatf("dly_frm_%0d", k), frameDone, (k == 8));
        end
        check("dly_cnt_wrap", shiftCount, 3'd0);
        cycle(1'b1, 2'b01, 1'b0, 1'b0, 8'h00);
        check("dly_frm_clr", frameDone, 1'b0);
        check("dly_cnt_next", shiftCount, 3'd1);
        check("dly_lsb_clr", serialOutLsb, 1'b0);

        // Serialise 0xA5 MSB-first via left shifts.
        cycle(1'b1, 2'b11, 1'b0, 1'b0, 8'hA5);
        check("ser_load_par", parOut, 8'hA5);
        check("ser_load_cnt", shiftCount, 3'd0);
        pattern = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("ser_msb_%0d", i), serialOutMsb, pattern[7-i]);
            cycle(1'b1, 2'b10, 1'b0, 1'b0, 8'h00);
        end
        check("ser_par_end", parOut, 8'h00);
        check("ser_frm", frameDone, 1'b1);
        check("ser_cnt", shiftCount, 3'd0);
        cycle(1'b1, 2'b00, 1'b0, 1'b0, 8'h00);
        check("ser_frm_once", frameDone, 1'b0);

        // Deserialise 0x3C LSB-first with a 3-cycle enable gap after bit 4.
        cycle(1'b1, 2'b11, 1'b0, 1'b0, 8'h00);
        pattern = 8'h3C;
        for (int i = 0; i < 4; i++) cycle(1'b1, 2'b01, pattern[i], 1'b0, 8'h00);
        check("des_cnt4", shiftCount, 3'd4);
        for (int g = 0; g < 3; g++) begin
            cycle(1'b0, 2'b01, 1'b1, 1'b1, 8'hFF);
            check($sformatf("des_gap_cnt_%0d", g), shiftCount, 3'd4);
            check($sformatf("des_gap_par_%0d", g), parOut, 8'hC0);
        end
        for (int i = 4; i < 8; i++) begin
            cycle(1'b1, 2'b01, pattern[i], 1'b0, 8'h00);
            check($sformatf("des_frm_%0d", i), frameDone, (i == 7));
        end
        check("des_par", parOut, 8'h3C);
        cycle(1'b0, 2'b01, 1'b1, 1'b0, 8'h00);
        check("des_frm_dis", frameDone, 1'b0);
        check("des_par_hold", parOut, 8'h3C);

        // Mixed directions: 5 right, 2 holds, 3 left share one frame.
        cycle(1'b1, 2'b11, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) cycle(1'b1, 2'b01, 1'b1, 1'b0, 8'h00);
        check("mix_par_r5", parOut, 8'hF8);
        cycle(1'b1, 2'b00, 1'b0, 1'b0, 8'h00);
        cycle(1'b1, 2'b00, 1'b0, 1'b0, 8'h00);
        check("mix_cnt_hold", shiftCount, 3'd5);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 2'b10, 1'b0, 1'b0, 8'h00);
            check($sformatf("mix_frm_l%0d", i), frameDone, (i == 2));
        end
        check("mix_par_end", parOut, 8'hC0);
        check("mix_cnt_end", shiftCount, 3'd0);

        // A load on the would-be frame edge wins.
        cycle(1'b1, 2'b11, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 7; i++) cycle(1'b1, 2'b01, 1'b0, 1'b0, 8'h00);
        check("ld7_cnt", shiftCount, 3'd7);
        cycle(1'b1, 2'b11, 1'b0, 1'b0, 8'hFF);
        check("ld7_frm", frameDone, 1'b0);
        check("ld7_cnt0", shiftCount, 3'd0);
        check("ld7_par", parOut, 8'hFF);

        // Reset mid-frame discards the partial frame.
        for (int i = 0; i < 6; i++) cycle(1'b1, 2'b10, 1'b1, 1'b1, 8'h00);
        check("rmf_cnt6", shiftCount, 3'd6);
        rst = 1'b1;
        cycle(1'b1, 2'b01, 1'b1, 1'b1, 8'h55);
        rst = 1'b0;
        check("rmf_par", parOut, 8'h00);
        check("rmf_cnt", shiftCount, 3'd0);
        check("rmf_frm", frameDone, 1'b0);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 2'b01, 1'b0, 1'b0, 8'h00);
            if (frameDone) pulses++;
        end
        check("rmf_frm_last", frameDone, 1'b1);
        cycle(1'b1, 2'b00, 1'b0, 1'b0, 8'h00);
        if (frameDone) pulses++;
        check("rmf_pulses", pulses, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/univ_shift_reg.md
# univ_shift_reg

Parametrised universal shift register generalising the fixed four-stage serial delay line: WIDTH stages with hold, shift-right, shift-left and parallel-load modes, a serial input and output at each end, a full parallel output, and a shift counter that flags each completed WIDTH-shift frame. It sits between parallel datapath logic and bit-serial links, serving as serialiser, deserialiser or programmable-length delay line.

## Interface
Parameters:
- WIDTH, 8, number of register stages; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  clock enable; when low, all state holds.
- mode  input  2  00 hold, 01 shift right, 10 shift left, 11 parallel load.
- serialInMsb  input  1  bit entering stage WIDTH-1 on a right shift.
- serialInLsb  input  1  bit entering stage 0 on a left shift.
- parIn  input  WIDTH  parallel load data.
- parOut  output  WIDTH  register contents q.
- serialOutLsb  output  1  q[0], combinational from q.
- serialOutMsb  output  1  q[WIDTH-1], combinational from q.
- shiftCount  output  CW  shifts since last reset, load or frame wrap; CW = $clog2(WIDTH).
- frameDone  output  1  registered one-cycle pulse on frame completion.

## Operation
- Reset: rst is sampled only on a rising clk edge and dominates enable and mode. After that edge, q = 0, shiftCount = 0, frameDone = 0. Consequently parOut = 0, serialOutLsb = 0 and serialOutMsb = 0.
- enable = 0: q and shiftCount hold. frameDone is 0 on the next edge.
- enable = 1, mode 00 (hold): q and shiftCount hold. frameDone <= 0.
- enable = 1, mode 01 (shift right): q <= {serialInMsb, q[WIDTH-1:1]}.
- enable = 1, mode 10 (shift left): q <= {q[WIDTH-2:0], serialInLsb}.
- enable = 1, mode 11 (load): q <= parIn, shiftCount <= 0, frameDone <= 0.
- Counting on a shift edge (mode 01 or 10):
  - If shiftCount = WIDTH-1: shiftCount <= 0 and frameDone <= 1.
  - Otherwise: shiftCount increments and frameDone <= 0.
- Right and left shifts both count toward the same frame. Changing direction mid-frame does not clear the count.
- There are no other states. The only sequential elements are q, shiftCount and frameDone.

## Timing
- All state updates occur on the rising edge of clk. There is no combinational path from inputs to outputs.
- Serial latency: a bit presented on serialInMsb in mode 01 appears on serialOutLsb after exactly WIDTH enabled shift edges. serialInLsb to serialOutMsb in mode 10 behaves the same.
- Load latency: parIn appears on parOut one edge after the load edge.
- frameDone:
  - High for the single cycle that follows the WIDTH-th shift edge since the last reset or load.
  - Low again after the next edge unless another frame completes on that edge. This requires WIDTH = 1, which is illegal, so back-to-back pulses never occur.
- Boundary conditions:
  - Counter wrap: the wrap and frameDone assertion happen on the same edge. Shifting continues seamlessly into the next frame.
  - Load on the edge that would have completed a frame: the load wins, so no frameDone and count becomes 0.
  - Reset mid-frame: q, count and frameDone clear on that edge. The partial frame is discarded.
  - enable deasserted mid-frame: the count is preserved and resumes on re-enable. A pending frameDone pulse still lasts exactly one cycle.
  - Shift inputs sampled while enable = 0 are ignored.

## Test plan
- Reset: apply rst for 2 cycles with random inputs, mode 11, enable 1 -> parOut = 0x00, shiftCount = 0, frameDone = 0. Release rst -> values hold until the first enabled operation.
- Delay line (WIDTH 8): mode 01, enable 1, drive serialInMsb = 1 for one cycle then 0 -> serialOutLsb = 1 exactly 8 edges after the input edge, 0 otherwise. frameDone pulses after edge 8.
- Serialise: load parIn = 0xA5, then 8 left shifts with serialInLsb = 0 -> serialOutMsb sequence 1,0,1,0,0,1,0,1. parOut = 0x00 at the end. frameDone high for one cycle after shift 8. shiftCount = 0.
- Deserialise with gaps: shift right bits of 0x3C LSB-first with enable low for 3 cycles after bit 4 -> shiftCount holds at 4 during the gap. parOut = 0x3C and frameDone pulses after the 8th enabled shift.
- Mixed modes: 5 right shifts, 2 holds, 3 left shifts -> frameDone after the 8th shift, i.e. the 3rd left. Load 0xFF at count 7 instead -> no frameDone, count 0, parOut = 0xFF.
- Reset mid-frame: after 6 shifts assert rst for one edge -> parOut = 0, count 0. A further 8 shifts produce exactly one frameDone.
